cipher_uart_tx: RTL and testbench

//   Downstream stage of the encrypt datapath: buffers 8-bit ciphertext bytes from encrypt.out
//   in a small FIFO and serialises each byte on a UART 8N1 line to the host.

---
 rtl/cipher_uart_tx.sv | 145 ++++++++++++++
 tb/tb_cipher_uart_tx.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_uart_tx.sv
`default_nettype none
// ============================================================================
// Module     : cipher_uart_tx
// Description: Ciphertext byte FIFO draining into a UART 8N1 transmitter.
// Revision   : 1.0
// ============================================================================
module cipher_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          push, pop, baud_wrap;

  always_comb begin
    push      = in_valid && in_ready;
    pop       = (state_q == IDLE) && (count_q != '0);
    baud_wrap = (baud_q == BAUD_MAX);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the current state one clock later, so tx is a clean flop output.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready   = (count_q != COUNT_FULL);
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cipher_uart_tx.sv
`default_nettype none
// ============================================================================
// Module     : tb_cipher_uart_tx
// Description: Self-checking bench for cipher_uart_tx (UART decode scoreboard).
// Revision   : 1.0
// ============================================================================
module tb_cipher_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data_w  [2];
  logic       in_valid_w [2];
  logic       rdy_w      [2];
  logic       tx_w       [2];
  logic       busy_w     [2];
  logic [2:0] cnt_w      [2];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q [2][$];
  logic [7:0] src [16];

  logic       m_act  [2];
  int         m_cnt  [2];
  logic [7:0] m_byte [2];
  int         rx_cnt [2];
  logic       space_chk [2];
  logic       have_fall [2];
  int         last_fall [2];
  int         slot;
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  cipher_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data_w[0]), .in_valid(in_valid_w[0]),
    .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0])
  );

  cipher_uart_tx #(.CLKS_PER_BIT(104), .FIFO_DEPTH(4)) dut_e2e (
    .clk(clk), .rst(rst), .in_data(in_data_w[1]), .in_valid(in_valid_w[1]),
    .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1])
  );

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 104;
  endfunction

  // Byte-wide cipher feeding in_data: rotate-xor-add of plaintext and key.
  function automatic logic [7:0] enc(input logic [7:0] k, input logic [7:0] p);
    logic [7:0] x;
    x = p ^ k;
    return {x[4:0], x[7:5]} + k;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid_w[i] && rdy_w[i]) exp_q[i].push_back(in_data_w[i]);
      end
    end
  end

  // UART receiver: mid-bit sampling from the detected start edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (tx_w[i] === 1'b0) begin
          m_act[i] = 1'b1;
          m_cnt[i] = 0;
          if (space_chk[i] && have_fall[i]) begin
            checks++;
            if (cyc - last_fall[i] != 10 * cpb(i) + 1) begin
              errors++;
              $display("FAIL start_spacing[%0d]: got %0d clocks, expected %0d", i, cyc - last_fall[i], 10 * cpb(i) + 1);
            end
          end
          last_fall[i] = cyc;
          have_fall[i] = 1'b1;
        end
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] >= cpb(i) / 2 && (m_cnt[i] - cpb(i) / 2) % cpb(i) == 0) begin
          slot = (m_cnt[i] - cpb(i) / 2) / cpb(i);
          if (slot == 0) begin
            checks++;
            if (tx_w[i] !== 1'b0) begin
              errors++;
              $display("FAIL start_bit[%0d]: got %b, expected 0", i, tx_w[i]);
            end
          end else if (slot <= 8) begin
            m_byte[i][slot-1] = tx_w[i];
          end else begin
            m_act[i] = 1'b0;
            rx_cnt[i]++;
            checks++;
            if (tx_w[i] !== 1'b1) begin
              errors++;
              $display("FAIL stop_bit[%0d]: got %b, expected 1", i, tx_w[i]);
            end
            checks++;
            if (exp_q[i].size() == 0) begin
              errors++;
              $display("FAIL rx_byte[%0d]: got unexpected frame %02h, expected none", i, m_byte[i]);
            end else begin
              exp_b = exp_q[i].pop_front();
              if (m_byte[i] !== exp_b) begin
                errors++;
                $display("FAIL rx_byte[%0d]: got %02h, expected %02h", i, m_byte[i], exp_b);
              end
            end
          end
        end
      end
    end
  end

  task automatic drive_src(input int inst, input int n);
    int k;
    int guard;
    k = 0;
    guard = 0;
    @(negedge clk);
    while (k < n && guard < 20000) begin
      in_valid_w[inst] = 1'b1;
      in_data_w[inst]  = rdy_w[inst] ? src[k] : 8'hEE;
      if (rdy_w[inst]) k++;
      @(negedge clk);
      guard++;
    end
    in_valid_w[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input int maxc, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < maxc && !ok) begin
      @(negedge clk);
      n++;
      if (!busy_w[inst] && !m_act[inst] && exp_q[inst].size() == 0) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1 || cnt_w[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_initial: tx=%b busy=%b in_ready=%b count=%0d, expected 1 0 1 0", tx_w[0], busy_w[0], rdy_w[0], cnt_w[0]);
    end
    rst = 1'b0;
    src[0] = 8'h5A;
    src[1] = 8'h6B;
    drive_src(0, 2);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1 || cnt_w[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: tx=%b busy=%b in_ready=%b count=%0d, expected 1 0 1 0", tx_w[0], busy_w[0], rdy_w[0], cnt_w[0]);
    end
    exp_q[0].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1 || cnt_w[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: tx=%b busy=%b in_ready=%b count=%0d, expected 1 0 1 0", tx_w[0], busy_w[0], rdy_w[0], cnt_w[0]);
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       expv;
    int         r0;
    bit         ok;
    b  = 8'hA5;
    r0 = rx_cnt[0];
    @(negedge clk);
    in_data_w[0]  = b;
    in_valid_w[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_w[0] = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 1 || k >= 38) expv = 1'b1;
      else if (k <= 5)       expv = 1'b0;
      else                   expv = b[(k - 6) / 4];
      checks++;
      if (tx_w[0] !== expv) begin
        errors++;
        $display("FAIL single_tx_cycle%0d: got %b, expected %b", k, tx_w[0], expv);
      end
      if (k == 40 || k == 42) begin
        checks++;
        if (busy_w[0] !== (k == 40)) begin
          errors++;
          $display("FAIL single_busy_cycle%0d: got %b, expected %b", k, busy_w[0], k == 40);
        end
      end
    end
    wait_idle(0, 100, ok);
    checks++;
    if (!ok || rx_cnt[0] - r0 != 1) begin
      errors++;
      $display("FAIL single_frames: got idle=%0d frames=%0d, expected idle=1 frames=1", ok, rx_cnt[0] - r0);
    end
  endtask

  task automatic test_burst();
    int r0;
    bit ok;
    bit saw_full;
    r0 = rx_cnt[0];
    saw_full = 1'b0;
    for (int k = 0; k < 6; k++) src[k] = 8'(k + 1);
    have_fall[0] = 1'b0;
    space_chk[0] = 1'b1;
    fork
      drive_src(0, 6);
      begin
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          checks++;
          if (rdy_w[0] !== (cnt_w[0] != 3'd4)) begin
            errors++;
            $display("FAIL burst_in_ready: got %b with count=%0d, expected %b", rdy_w[0], cnt_w[0], cnt_w[0] != 3'd4);
          end
          if (cnt_w[0] == 3'd4) saw_full = 1'b1;
        end
      end
    join
    wait_idle(0, 400, ok);
    space_chk[0] = 1'b0;
    checks++;
    if (!ok || !saw_full || rx_cnt[0] - r0 != 6) begin
      errors++;
      $display("FAIL burst_done: got idle=%0d full_seen=%0d frames=%0d, expected 1 1 6", ok, saw_full, rx_cnt[0] - r0);
    end
  endtask

  task automatic test_full_boundary();
    int r0;
    int n;
    bit ok;
    r0 = rx_cnt[0];
    for (int k = 0; k < 6; k++) src[k] = 8'(8'h80 + k);
    fork
      drive_src(0, 6);
      begin
        n = 0;
        while (cnt_w[0] != 3'd4 && n < 30) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (cnt_w[0] !== 3'd4) begin
          errors++;
          $display("FAIL full_reach: got count=%0d, expected 4", cnt_w[0]);
        end else begin
          checks++;
          if (in_valid_w[0] !== 1'b1 || rdy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got in_valid=%b in_ready=%b, expected 1 0", in_valid_w[0], rdy_w[0]);
          end
          @(negedge clk);
          checks++;
          if (cnt_w[0] !== 3'd4) begin
            errors++;
            $display("FAIL full_no_take: got count=%0d, expected 4", cnt_w[0]);
          end
          n = 0;
          while (cnt_w[0] == 3'd4 && n < 60) begin
            @(negedge clk);
            n++;
          end
          checks++;
          if (cnt_w[0] !== 3'd3 || rdy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: got count=%0d in_ready=%b, expected 3 1", cnt_w[0], rdy_w[0]);
          end
          @(negedge clk);
          checks++;
          if (cnt_w[0] !== 3'd4) begin
            errors++;
            $display("FAIL full_refill: got count=%0d, expected 4", cnt_w[0]);
          end
        end
      end
    join
    wait_idle(0, 400, ok);
    checks++;
    if (!ok || rx_cnt[0] - r0 != 6) begin
      errors++;
      $display("FAIL full_done: got idle=%0d frames=%0d, expected 1 6", ok, rx_cnt[0] - r0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int         r0;
    bit         ok;
    bit         bad;
    b = 8'h11;
    src[0] = b;
    src[1] = 8'h22;
    src[2] = 8'h33;
    drive_src(0, 3);
    repeat (17) @(negedge clk);
    checks++;
    if (tx_w[0] !== b[3] || cnt_w[0] !== 3'd2) begin
      errors++;
      $display("FAIL midrst_pre: got tx=%b count=%0d, expected %b 2", tx_w[0], cnt_w[0], b[3]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || cnt_w[0] !== 3'd0 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: got tx=%b count=%0d busy=%b in_ready=%b, expected 1 0 0 1", tx_w[0], cnt_w[0], busy_w[0], rdy_w[0]);
    end
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = rx_cnt[0];
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_quiet: got activity after reset, expected tx=1 busy=0 throughout");
    end
    src[0] = 8'h3C;
    drive_src(0, 1);
    wait_idle(0, 100, ok);
    checks++;
    if (!ok || rx_cnt[0] - r0 != 1) begin
      errors++;
      $display("FAIL midrst_clean_frame: got idle=%0d frames=%0d, expected 1 1", ok, rx_cnt[0] - r0);
    end
  endtask

  task automatic test_end_to_end();
    logic [7:0] key;
    logic [7:0] pt;
    int         r1;
    bit         ok;
    r1 = rx_cnt[1];
    for (int k = 0; k < 16; k++) begin
      key    = 8'($urandom);
      pt     = 8'($urandom);
      src[k] = enc(key, pt);
    end
    drive_src(1, 16);
    wait_idle(1, 20000, ok);
    checks++;
    if (!ok || rx_cnt[1] - r1 != 16) begin
      errors++;
      $display("FAIL e2e_done: got idle=%0d frames=%0d, expected 1 16", ok, rx_cnt[1] - r1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_data_w[i]  = 8'h00;
      in_valid_w[i] = 1'b0;
      m_act[i]      = 1'b0;
      m_cnt[i]      = 0;
      m_byte[i]     = 8'h00;
      rx_cnt[i]     = 0;
      space_chk[i]  = 1'b0;
      have_fall[i]  = 1'b0;
      last_fall[i]  = 0;
    end
    test_reset();
    test_single();
    test_burst();
    test_full_boundary();
    test_reset_mid_frame();
    test_end_to_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
